dco_cfg_seq: RTL and testbench
==============================

Name: dco_cfg_seq

Overview:
- Register-bus initiator that programs the DCO configuration register block (cc_sel, fc_sel, div_sel, freq_sel) from a single start command.
- Optionally reads each register back and checks it.
- Waits a programmable settle time after the last write, then reports done or a coded error.
- Sits between the SoC clock-control logic (boot FSM / DVFS controller) and the DCO register block, on the same reg_req_t/reg_rsp_t bus.

Parameters:
- reg_req_t, logic, request struct with fields valid, write, addr, wdata, wstrb.
- reg_rsp_t, logic, response struct with fields ready, rdata, error.
- ADDR_WIDTH, 32, width of req.addr.
- DATA_WIDTH, 64, width of req.wdata and rsp.rdata.
- BASE_ADDR, 32'h0, DCO register block base. Register offsets: 0x000 cc, 0x008 fc, 0x010 div, 0x018 freq.
- SETTLE_CYCLES, 16, wait after the final write before done. Must be ≥1.
- TIMEOUT_CYCLES, 256, max cycles a request may stay valid without ready.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle request to program the DCO. Ignored while busy_o=1.
- verify_en_i  in  1  enables readback check. Sampled with start_i.
- cc_sel_i  in  6  target cc_sel.
- fc_sel_i  in  6  target fc_sel.
- div_sel_i  in  3  target div_sel.
- freq_sel_i  in  2  target freq_sel.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse at sequence end, success or failure.
- err_code_o  out  2  0 ok, 1 bus error, 2 verify mismatch, 3 timeout. Held until the next accepted start.
- err_idx_o  out  2  register index (0 cc, 1 fc, 2 div, 3 freq) of the first error.
- req_o  out  reg_req_t  bus request.
- rsp_i  in  reg_rsp_t  bus response.

Behaviour:
- Reset values: busy_o=0, done_o=0, err_code_o=0, err_idx_o=0, req_o all fields 0, shadow config 0, FSM in IDLE.
- Reset asserted mid-transaction drops req_o.valid asynchronously. No transaction is resumed after reset.
- Start acceptance: start_i=1 in IDLE latches cc/fc/div/freq/verify_en into shadow registers, clears err_code_o/err_idx_o, sets idx=0, and moves to WRITE. Later input changes have no effect on the sequence.
- Handshake: a transaction completes in the cycle where valid&ready=1. While valid=1 and ready=0, addr/write/wdata/wstrb are held stable. valid deasserts in the cycle after completion. The next request may assert no earlier than that cycle, so there is exactly one idle bus cycle between transactions.
- wdata: target value zero-extended to DATA_WIDTH. wstrb: all ones. addr = BASE_ADDR + idx*8.
- FSM states: IDLE, WRITE, READ, SETTLE, FINISH.
  - IDLE → WRITE on start.
  - WRITE: issue the write for idx.
    - On completion with error=0: if idx<3, idx++ and stay in WRITE.
    - If idx=3: go to READ with idx=0 when verify_en, else to SETTLE.
  - READ: issue the read for idx and compare rdata[field width-1:0] with the shadow value. Upper bits are ignored.
    - On match: idx++, or go to SETTLE after idx=3.
  - SETTLE: count SETTLE_CYCLES cycles, then FINISH.
  - FINISH: assert done_o for one cycle, then IDLE. busy_o is low in that same cycle.
- Errors:
  - rsp.error=1 on a completing transaction → err_code=1.
  - Readback mismatch → err_code=2.
  - Transaction valid for TIMEOUT_CYCLES cycles without ready → deassert valid, err_code=3.
  - Every error records err_idx and jumps straight to FINISH; SETTLE is skipped. Only the first error is recorded.
- Timeout counter clears at each new request.
- A start_i coinciding with the FINISH cycle is ignored.
- Total latency with a zero-wait responder, no verify: 4 writes × 2 cycles + SETTLE_CYCLES + 1 cycles from the start cycle to done_o.

Decomposition:
- Shared package dco_pkg holds:
  - register offsets (DCO_CC_OFFS=12'h000, DCO_FC_OFFS=12'h008, DCO_DIV_OFFS=12'h010, DCO_FREQ_OFFS=12'h018);
  - field widths;
  - reset defaults (cc 6'h3F, fc 6'h3F, div 3'b100, freq 2'b11);
  - error code enum dco_err_e;
  - FSM state enum.
- One natural sub-module, dco_reg_xfer: a single-transaction bus initiator handling the valid/ready hold, the timeout counter, and the done/error/rdata return. The sequencer FSM instantiates it once.

Test Plan:
- Zero-wait responder (the DCO register block), verify off, cc=0x15 fc=0x2A div=3 freq=1 → writes to offsets 0x000/0x008/0x010/0x018 with wdata 0x15/0x2A/0x3/0x1. done_o 8+16+1 cycles after start, err_code=0, and the register block outputs match.
- Same config with verify on and a random 0–5 cycle ready delay → 4 writes then 4 reads in order. req fields stable while ready=0. done_o with err_code=0.
- Responder corrupts the fc readback to 0x2B → err_code=2, err_idx=1. No freq read issued, done_o without settle delay.
- Responder returns error=1 on the div write → err_code=1, err_idx=2. No freq write issued.
- Responder never asserts ready on the cc write → valid deasserts after 256 cycles, err_code=3, err_idx=0. A second start clears the error and succeeds against a good responder.
- rst_n pulsed low during the fc write with ready stalled → req_o.valid=0 and busy_o=0 immediately. start_i held during busy is ignored: exactly 4 writes per sequence.

Source files
------------

// File: rtl/dco_pkg.sv
// Purpose: shared types and constants for the DCO configuration sequencer and its bus initiator.
// Latency: none (declarations only).
// Backpressure: n/a.
package dco_pkg;

    // Bus geometry used by the default request/response structs.
    localparam int DCO_AW = 32;
    localparam int DCO_DW = 64;

    // Register offsets inside the DCO register block.
    localparam logic [11:0] DCO_CC_OFFS   = 12'h000;
    localparam logic [11:0] DCO_FC_OFFS   = 12'h008;
    localparam logic [11:0] DCO_DIV_OFFS  = 12'h010;
    localparam logic [11:0] DCO_FREQ_OFFS = 12'h018;

    // Field widths.
    localparam int CC_W   = 6;
    localparam int FC_W   = 6;
    localparam int DIV_W  = 3;
    localparam int FREQ_W = 2;

    // Container width wide enough for any single field.
    localparam int FLD_W = 8;

    // Register block reset defaults.
    localparam logic [CC_W-1:0]   DCO_CC_RST   = 6'h3F;
    localparam logic [FC_W-1:0]   DCO_FC_RST   = 6'h3F;
    localparam logic [DIV_W-1:0]  DCO_DIV_RST  = 3'b100;
    localparam logic [FREQ_W-1:0] DCO_FREQ_RST = 2'b11;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BUS     = 2'd1,
        ERR_VERIFY  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } dco_err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_SETTLE,
        ST_FINISH
    } dco_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [DCO_AW-1:0]     addr;
        logic [DCO_DW-1:0]     wdata;
        logic [DCO_DW/8-1:0]   wstrb;
    } dco_req_t;

    typedef struct packed {
        logic                  ready;
        logic [DCO_DW-1:0]     rdata;
        logic                  error;
    } dco_rsp_t;

    typedef struct packed {
        logic [CC_W-1:0]   cc;
        logic [FC_W-1:0]   fc;
        logic [DIV_W-1:0]  div;
        logic [FREQ_W-1:0] freq;
    } dco_cfg_t;

    function automatic logic [11:0] dco_offs(input logic [1:0] idx);
        logic [11:0] o;
        case (idx)
            2'd0:    o = DCO_CC_OFFS;
            2'd1:    o = DCO_FC_OFFS;
            2'd2:    o = DCO_DIV_OFFS;
            default: o = DCO_FREQ_OFFS;
        endcase
        return o;
    endfunction

    // Field value for register idx, zero-extended to FLD_W.
    function automatic logic [FLD_W-1:0] dco_field(input dco_cfg_t c, input logic [1:0] idx);
        logic [FLD_W-1:0] f;
        case (idx)
            2'd0:    f = {{(FLD_W-CC_W){1'b0}},   c.cc};
            2'd1:    f = {{(FLD_W-FC_W){1'b0}},   c.fc};
            2'd2:    f = {{(FLD_W-DIV_W){1'b0}},  c.div};
            default: f = {{(FLD_W-FREQ_W){1'b0}}, c.freq};
        endcase
        return f;
    endfunction

    // Bits of readback data that belong to the field of register idx.
    function automatic logic [FLD_W-1:0] dco_mask(input logic [1:0] idx);
        logic [FLD_W-1:0] m;
        case (idx)
            2'd0:    m = FLD_W'((1 << CC_W) - 1);
            2'd1:    m = FLD_W'((1 << FC_W) - 1);
            2'd2:    m = FLD_W'((1 << DIV_W) - 1);
            default: m = FLD_W'((1 << FREQ_W) - 1);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dco_reg_xfer.sv
// Purpose: single-transaction register-bus initiator; holds a request until ready or timeout.
// Latency: valid the cycle after go; done pulses the cycle after valid&ready (or after timeout).
// Backpressure: request fields frozen while ready=0; valid dropped after TIMEOUT_CYCLES stalled cycles.
//
// Ports: clk/rst_n; go + go_write/go_addr/go_wdata launch a transaction (ignored while one
// is outstanding); req_o/rsp_i bus; done pulse with err_bus, err_tmo and captured rdata.
module dco_reg_xfer
    import dco_pkg::*;
#(
    parameter type reg_req_t      = dco_req_t,
    parameter type reg_rsp_t      = dco_rsp_t,
    parameter int  ADDR_WIDTH     = DCO_AW,
    parameter int  DATA_WIDTH     = DCO_DW,
    parameter int  TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  go_write,
    input  logic [ADDR_WIDTH-1:0] go_addr,
    input  logic [DATA_WIDTH-1:0] go_wdata,
    output reg_req_t              req_o,
    input  reg_rsp_t              rsp_i,
    output logic                  done,
    output logic                  err_bus,
    output logic                  err_tmo,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_o   <= '0;
            tmo_cnt <= '0;
            done    <= 1'b0;
            err_bus <= 1'b0;
            err_tmo <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            if (req_o.valid) begin
                if (rsp_i.ready) begin
                    req_o.valid <= 1'b0;
                    done        <= 1'b1;
                    err_bus     <= rsp_i.error;
                    err_tmo     <= 1'b0;
                    rdata       <= rsp_i.rdata;
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    // This is the last stalled cycle allowed; give up on the request.
                    req_o.valid <= 1'b0;
                    done        <= 1'b1;
                    err_bus     <= 1'b0;
                    err_tmo     <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else if (go) begin
                // valid is low here, so a new request always follows at least one idle cycle.
                req_o.valid <= 1'b1;
                req_o.write <= go_write;
                req_o.addr  <= go_addr;
                req_o.wdata <= go_wdata;
                req_o.wstrb <= '1;
                tmo_cnt     <= '0;
            end
        end
    end

endmodule

// File: rtl/dco_cfg_seq.sv
// Purpose: programs cc/fc/div/freq DCO registers from one start, optional readback check, settle wait.
// Latency: zero-wait bus, no verify: done_o 8 + SETTLE_CYCLES + 1 cycles after the start cycle.
// Backpressure: stalls on bus ready; a request stalled TIMEOUT_CYCLES cycles ends with a timeout error.
//
// Ports: clk/rst_n; start_i + verify_en_i + cc/fc/div/freq_sel_i command; busy_o, done_o,
// err_code_o (0 ok, 1 bus, 2 verify, 3 timeout), err_idx_o; req_o/rsp_i register bus.
module dco_cfg_seq
    import dco_pkg::*;
#(
    parameter type                   reg_req_t      = dco_req_t,
    parameter type                   reg_rsp_t      = dco_rsp_t,
    parameter int                    ADDR_WIDTH     = DCO_AW,
    parameter int                    DATA_WIDTH     = DCO_DW,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    SETTLE_CYCLES  = 16,   // must be >= 1
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              verify_en_i,
    input  logic [CC_W-1:0]   cc_sel_i,
    input  logic [FC_W-1:0]   fc_sel_i,
    input  logic [DIV_W-1:0]  div_sel_i,
    input  logic [FREQ_W-1:0] freq_sel_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        err_code_o,
    output logic [1:0]        err_idx_o,
    output reg_req_t          req_o,
    input  reg_rsp_t          rsp_i
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    dco_state_e      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    dco_cfg_t        cfg_q, cfg_d, cfg_in, go_cfg;
    logic            verify_q, verify_d;
    logic [SW-1:0]   settle_q, settle_d;
    dco_err_e        err_code_q, err_code_d;
    logic [1:0]      err_idx_q, err_idx_d;

    logic                  go, go_write;
    logic [1:0]            go_idx;
    logic [ADDR_WIDTH-1:0] go_addr;
    logic [DATA_WIDTH-1:0] go_wdata;
    logic                  x_done, x_err_bus, x_err_tmo;
    logic [DATA_WIDTH-1:0] x_rdata;
    logic                  rd_mismatch;

    assign cfg_in = '{cc: cc_sel_i, fc: fc_sel_i, div: div_sel_i, freq: freq_sel_i};

    // Only the field bits of the readback are compared; everything above is don't-care.
    assign rd_mismatch = (x_rdata & DATA_WIDTH'(dco_mask(idx_q)))
                         != DATA_WIDTH'(dco_field(cfg_q, idx_q));

    assign go_addr  = BASE_ADDR + ADDR_WIDTH'(dco_offs(go_idx));
    assign go_wdata = go_write ? DATA_WIDTH'(dco_field(go_cfg, go_idx)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cfg_q      <= '0;
            verify_q   <= 1'b0;
            settle_q   <= '0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cfg_q      <= cfg_d;
            verify_q   <= verify_d;
            settle_q   <= settle_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cfg_d      = cfg_q;
        verify_d   = verify_q;
        settle_d   = settle_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
        go         = 1'b0;
        go_write   = 1'b1;
        go_idx     = idx_q;
        go_cfg     = cfg_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cfg_d      = cfg_in;
                    verify_d   = verify_en_i;
                    err_code_d = ERR_NONE;
                    err_idx_d  = '0;
                    idx_d      = '0;
                    state_d    = ST_WRITE;
                    // Launch the first write now so it is on the bus the next cycle;
                    // the shadow is not loaded yet, so take the data from the inputs.
                    go         = 1'b1;
                    go_idx     = '0;
                    go_cfg     = cfg_in;
                end
            end

            ST_WRITE: begin
                if (x_done) begin
                    if (x_err_bus || x_err_tmo) begin
                        err_code_d = x_err_tmo ? ERR_TIMEOUT : ERR_BUS;
                        err_idx_d  = idx_q;
                        state_d    = ST_FINISH;
                    end else if (idx_q != 2'd3) begin
                        idx_d  = idx_q + 2'd1;
                        go     = 1'b1;
                        go_idx = idx_q + 2'd1;
                    end else if (verify_q) begin
                        idx_d    = '0;
                        state_d  = ST_READ;
                        go       = 1'b1;
                        go_write = 1'b0;
                        go_idx   = '0;
                    end else begin
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end
                end
            end

            ST_READ: begin
                if (x_done) begin
                    if (x_err_bus || x_err_tmo) begin
                        err_code_d = x_err_tmo ? ERR_TIMEOUT : ERR_BUS;
                        err_idx_d  = idx_q;
                        state_d    = ST_FINISH;
                    end else if (rd_mismatch) begin
                        err_code_d = ERR_VERIFY;
                        err_idx_d  = idx_q;
                        state_d    = ST_FINISH;
                    end else if (idx_q != 2'd3) begin
                        idx_d    = idx_q + 2'd1;
                        go       = 1'b1;
                        go_write = 1'b0;
                        go_idx   = idx_q + 2'd1;
                    end else begin
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_FINISH;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end

            ST_FINISH: begin
                // A start seen here is dropped: FINISH always returns to IDLE.
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o     = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_SETTLE);
    assign done_o     = (state_q == ST_FINISH);
    assign err_code_o = err_code_q;
    assign err_idx_o  = err_idx_q;

    dco_reg_xfer #(
        .reg_req_t      (reg_req_t),
        .reg_rsp_t      (reg_rsp_t),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xfer (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .go_write (go_write),
        .go_addr  (go_addr),
        .go_wdata (go_wdata),
        .req_o    (req_o),
        .rsp_i    (rsp_i),
        .done     (x_done),
        .err_bus  (x_err_bus),
        .err_tmo  (x_err_tmo),
        .rdata    (x_rdata)
    );

endmodule

// File: tb/tb_dco_cfg_seq.sv
// Purpose: self-checking bench for dco_cfg_seq with a behavioural DCO register block responder.
// Latency: n/a.
// Backpressure: responder inserts programmable ready delay, stalls, errors and readback corruption.
module tb_dco_cfg_seq;
    import dco_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, verify_en_i;
    logic [5:0]  cc_sel_i, fc_sel_i;
    logic [2:0]  div_sel_i;
    logic [1:0]  freq_sel_i;
    logic        busy_o, done_o;
    logic [1:0]  err_code_o, err_idx_o;
    dco_req_t    req_o;
    dco_rsp_t    rsp;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dco_cfg_seq #(
        .SETTLE_CYCLES  (16),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .verify_en_i (verify_en_i),
        .cc_sel_i    (cc_sel_i),
        .fc_sel_i    (fc_sel_i),
        .div_sel_i   (div_sel_i),
        .freq_sel_i  (freq_sel_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_code_o  (err_code_o),
        .err_idx_o   (err_idx_o),
        .req_o       (req_o),
        .rsp_i       (rsp)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- register block model / responder ----------------
    logic [7:0]  regs [4];
    int          cur_dly, cur_err_wr, cur_bad_rd, cur_stall;
    int          stab_bad, run, last_run, n_log, wait_left;
    logic        pending;
    dco_req_t    held;
    logic        log_wr    [16];
    logic [31:0] log_addr  [16];
    logic [63:0] log_wdata [16];
    logic [7:0]  log_wstrb [16];

    function automatic logic [7:0] msk(input int i);
        logic [7:0] m;
        case (i)
            0, 1:    m = 8'h3F;
            2:       m = 8'h07;
            default: m = 8'h03;
        endcase
        return m;
    endfunction

    task automatic model_reset();
        regs[0] = 8'(DCO_CC_RST);
        regs[1] = 8'(DCO_FC_RST);
        regs[2] = 8'(DCO_DIV_RST);
        regs[3] = 8'(DCO_FREQ_RST);
        n_log    = 0;
        stab_bad = 0;
        last_run = 0;
    endtask

    initial begin
        int         ridx;
        logic [7:0] val;
        logic [63:0] rb;
        rsp = '0;
        pending = 1'b0;
        run = 0;
        wait_left = 0;
        forever begin
            @(negedge clk);
            rsp = '0;
            if (!rst_n) begin
                pending = 1'b0;
                run = 0;
            end else if (req_o.valid) begin
                ridx = int'(req_o.addr[4:3]);
                run++;
                if (!pending) begin
                    pending   = 1'b1;
                    held      = req_o;
                    wait_left = int'($urandom_range(cur_dly, 0));
                    if (n_log < 16) begin
                        log_wr[n_log]    = req_o.write;
                        log_addr[n_log]  = req_o.addr;
                        log_wdata[n_log] = req_o.wdata;
                        log_wstrb[n_log] = req_o.wstrb;
                    end
                    n_log++;
                end else if (req_o != held) begin
                    stab_bad++;
                end
                if (ridx != cur_stall && wait_left == 0) begin
                    rsp.ready = 1'b1;
                    if (req_o.write) begin
                        if (ridx == cur_err_wr) rsp.error = 1'b1;
                        else regs[ridx] = req_o.wdata[7:0] & msk(ridx);
                    end else begin
                        rb  = {$urandom(), $urandom()};
                        val = regs[ridx];
                        if (ridx == cur_bad_rd) val = val ^ 8'h01;
                        rb[7:0] = (val & msk(ridx)) | (rb[7:0] & ~msk(ridx));
                        rsp.rdata = rb;
                    end
                    pending = 1'b0;
                end else if (wait_left > 0) begin
                    wait_left--;
                end
            end else begin
                pending = 1'b0;
                if (run > 0) last_run = run;
                run = 0;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       verify;
        logic [5:0] cc, fc;
        logic [2:0] div;
        logic [1:0] freq;
        int         dly, err_wr, bad_rd, stall, exp_lat;
        logic [1:0] exp_err, exp_idx;
        int         exp_nwr, exp_nrd;
    } vec_t;

    vec_t tv [8];

    function automatic logic [63:0] fld(input vec_t v, input int i);
        logic [63:0] f;
        case (i)
            0:       f = 64'(v.cc);
            1:       f = 64'(v.fc);
            2:       f = 64'(v.div);
            default: f = 64'(v.freq);
        endcase
        return f;
    endfunction

    initial begin
        int   got, lat, nwr, nrd, obad, vseen;
        start_i = 0; verify_en_i = 0;
        cc_sel_i = 0; fc_sel_i = 0; div_sel_i = 0; freq_sel_i = 0;
        cur_dly = 0; cur_err_wr = -1; cur_bad_rd = -1; cur_stall = -1;
        model_reset();
        rst_n = 0;

        //          vfy cc     fc     div   frq   dly err bad stl lat  err idx wr rd
        tv[0] = '{1'b0, 6'h15, 6'h2A, 3'd3, 2'd1, 0, -1, -1, -1,  25, 2'd0, 2'd0, 4, 0};
        tv[1] = '{1'b0, 6'h01, 6'h3E, 3'd5, 2'd2, 0, -1, -1, -1,  25, 2'd0, 2'd0, 4, 0};
        tv[2] = '{1'b1, 6'h15, 6'h2A, 3'd3, 2'd1, 0, -1, -1, -1,  33, 2'd0, 2'd0, 4, 4};
        tv[3] = '{1'b1, 6'h15, 6'h2A, 3'd3, 2'd1, 5, -1, -1, -1,  -1, 2'd0, 2'd0, 4, 4};
        tv[4] = '{1'b1, 6'h15, 6'h2A, 3'd3, 2'd1, 0, -1,  1, -1,  13, 2'd2, 2'd1, 4, 2};
        tv[5] = '{1'b1, 6'h15, 6'h2A, 3'd3, 2'd1, 0,  2, -1, -1,   7, 2'd1, 2'd2, 3, 0};
        tv[6] = '{1'b0, 6'h15, 6'h2A, 3'd3, 2'd1, 0, -1, -1,  0, 258, 2'd3, 2'd0, 1, 0};
        tv[7] = '{1'b1, 6'h3F, 6'h00, 3'd7, 2'd2, 3, -1, -1, -1,  -1, 2'd0, 2'd0, 4, 4};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err_code", err_code_o, 0);
        chk("rst_err_idx", err_idx_o, 0);
        chk("rst_req", req_o, 0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            model_reset();
            cur_dly = tv[i].dly; cur_err_wr = tv[i].err_wr;
            cur_bad_rd = tv[i].bad_rd; cur_stall = tv[i].stall;
            verify_en_i = tv[i].verify;
            cc_sel_i = tv[i].cc; fc_sel_i = tv[i].fc;
            div_sel_i = tv[i].div; freq_sel_i = tv[i].freq;
            start_i = 1;
            lat = cyc;
            @(negedge clk);
            start_i = 0;
            // Inputs change after acceptance; the sequence must use the latched copy.
            cc_sel_i = ~tv[i].cc; fc_sel_i = ~tv[i].fc;
            div_sel_i = ~tv[i].div; freq_sel_i = ~tv[i].freq; verify_en_i = ~tv[i].verify;
            chk($sformatf("v%0d_busy_after_start", i), busy_o, 1);
            chk($sformatf("v%0d_err_cleared", i), err_code_o, 0);
            got = 0;
            for (int k = 0; k < 2000; k++) begin
                if (done_o) begin got = 1; break; end
                @(negedge clk);
            end
            chk($sformatf("v%0d_done_seen", i), got, 1);
            lat = cyc - lat;
            if (tv[i].exp_lat >= 0) chk($sformatf("v%0d_latency", i), lat, tv[i].exp_lat);
            chk($sformatf("v%0d_busy_at_done", i), busy_o, 0);
            chk($sformatf("v%0d_err_code", i), err_code_o, tv[i].exp_err);
            chk($sformatf("v%0d_err_idx", i), err_idx_o, tv[i].exp_idx);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), done_o, 0);

            nwr = 0; nrd = 0; obad = 0;
            for (int j = 0; j < n_log && j < 16; j++) begin
                if (log_wr[j]) begin
                    if (j != nwr || log_addr[j] != 32'(nwr * 8) || log_wdata[j] != fld(tv[i], nwr)
                        || log_wstrb[j] != 8'hFF) obad++;
                    nwr++;
                end else begin
                    if (log_addr[j] != 32'(nrd * 8)) obad++;
                    nrd++;
                end
            end
            chk($sformatf("v%0d_n_writes", i), nwr, tv[i].exp_nwr);
            chk($sformatf("v%0d_n_reads", i), nrd, tv[i].exp_nrd);
            chk($sformatf("v%0d_order", i), obad, 0);
            chk($sformatf("v%0d_stable", i), stab_bad, 0);
            if (tv[i].exp_err == 2'd0)
                chk($sformatf("v%0d_regs", i), {regs[0], regs[1], regs[2], regs[3]},
                    {2'b0, tv[i].cc, 2'b0, tv[i].fc, 5'b0, tv[i].div, 6'b0, tv[i].freq});
            if (tv[i].stall >= 0)
                chk($sformatf("v%0d_timeout_valid_cycles", i), last_run, 256);
        end

        // Asynchronous reset during a stalled fc write
        model_reset();
        cur_dly = 0; cur_err_wr = -1; cur_bad_rd = -1; cur_stall = 1;
        verify_en_i = 0; cc_sel_i = 6'h15; fc_sel_i = 6'h2A; div_sel_i = 3'd3; freq_sel_i = 2'd1;
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        got = 0;
        for (int k = 0; k < 100; k++) begin
            if (req_o.valid && req_o.addr[4:3] == 2'd1) begin got = 1; break; end
            @(negedge clk);
        end
        chk("arst_reached_fc", got, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", req_o.valid, 0);
        chk("arst_busy", busy_o, 0);
        @(posedge clk);
        #2 rst_n = 1;
        cur_stall = -1;
        vseen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_o.valid || busy_o) vseen++;
        end
        chk("arst_no_resume", vseen, 0);

        // start_i held through the whole sequence and through FINISH
        model_reset();
        start_i = 1;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done_o) begin got = 1; break; end
        end
        chk("held_done_seen", got, 1);
        @(negedge clk);
        start_i = 0;
        repeat (5) @(negedge clk);
        chk("held_start_writes", n_log, 4);
        chk("held_idle_after", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
